// File: rtl/exp1_8_seq_checker.sv
// ---------------------------------------------------------------------------
// exp1_8_seq_checker
//
// Receiving end of the exp1_8 step-sequence interface. The checker follows
// the producer's step index (i) and in-step counter (c1). It confirms that the
// data fields (x, y, act1, act2) hold stable inside a step and flags any
// deviation from the expected sequence. At each step boundary it captures the
// action codes, and it keeps error and step statistics.
//
// Sequence seen on chk_en samples:
//   c1 counts 0..STEP_LEN-1. After STEP_LEN-1 the next sample has c1 = 0 and
//   i advances by one modulo 4. The data fields may change only on c1 = 0.
//
// Optional feature (macro EXP1_8_AUTO_RESYNC_EN):
//   defined   : ERROR lasts one clock, then the checker hunts again by itself.
//   undefined : ERROR is absorbing until clr_err or rst_n.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   chk_en    in   1      sample enable; inputs ignored while low
//   c1        in   W      producer in-step cycle counter
//   x, y      in   W      producer data
//   act1/2    in   W      producer action codes
//   i         in   2      producer step index
//   clr_err   in   1      synchronous clear of err_cnt, err_flag and ERROR
//   locked    out  1      synchronised to the sequence (registered)
//   err_pulse out  1      one-cycle pulse after each mismatching sample
//   err_flag  out  1      sticky error indicator
//   err_cnt   out  CNT_W  saturating mismatch count
//   step_cnt  out  CNT_W  completed steps while locked (wraps)
//   cap_act1  out  W      act1 captured on the last cycle of a step
//   cap_act2  out  W      act2 captured on the last cycle of a step
//   cap_step  out  2      step index of the captured step
// ---------------------------------------------------------------------------
module exp1_8_seq_checker #(
  parameter int STEP_LEN = 8,
  parameter int W        = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic [W-1:0]     c1,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     act1,
  input  logic [W-1:0]     act2,
  input  logic [1:0]       i,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] step_cnt,
  output logic [W-1:0]     cap_act1,
  output logic [W-1:0]     cap_act2,
  output logic [1:0]       cap_step
);

  // The last in-step count is compared at width W, so it is truncated to W.
  localparam logic [W-1:0]     LAST_C1  = W'(STEP_LEN - 1);
  localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  // True when any data field differs from the latched step reference.
  function automatic logic data_differs(
    input logic [W-1:0] x_now,  input logic [W-1:0] x_ref,
    input logic [W-1:0] y_now,  input logic [W-1:0] y_ref,
    input logic [W-1:0] a1_now, input logic [W-1:0] a1_ref,
    input logic [W-1:0] a2_now, input logic [W-1:0] a2_ref
  );
    return (x_now != x_ref) || (y_now != y_ref) ||
           (a1_now != a1_ref) || (a2_now != a2_ref);
  endfunction

  state_t           state_r;
  state_t           state_s;
  state_t           state_nxt_s;
  logic [W-1:0]     exp_c1_r;
  logic [W-1:0]     exp_c1_s;
  logic [1:0]       exp_i_r;
  logic [1:0]       exp_i_s;
  logic [W-1:0]     ref_x_r;
  logic [W-1:0]     ref_y_r;
  logic [W-1:0]     ref_act1_r;
  logic [W-1:0]     ref_act2_r;
  logic             latch_s;
  logic             step_done_s;
  logic             mismatch_s;

  logic             locked_r;
  logic             err_pulse_r;
  logic             err_flag_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic [W-1:0]     cap_act1_r;
  logic [W-1:0]     cap_act2_r;
  logic [1:0]       cap_step_r;

  // Next-state and sequence-compare logic for the hunt/locked/error FSM.
  always_comb begin
    state_s     = state_r;
    exp_c1_s    = exp_c1_r;
    exp_i_s     = exp_i_r;
    latch_s     = 1'b0;
    step_done_s = 1'b0;
    mismatch_s  = 1'b0;
    case (state_r)
      ST_HUNT: begin
        // Synchronisation only happens on the very first sample of step 0.
        if (chk_en && (c1 == ZERO_W) && (i == 2'd0)) begin
          state_s  = ST_LOCKED;
          exp_c1_s = ONE_W;
          exp_i_s  = 2'd0;
          latch_s  = 1'b1;
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (chk_en) begin
          // On c1 = 0 the data fields may legally change, so they are not
          // compared there; they are relatched as the new step reference.
          mismatch_s = (c1 != exp_c1_r) || (i != exp_i_r) ||
                       ((c1 != ZERO_W) &&
                        data_differs(x, ref_x_r, y, ref_y_r,
                                     act1, ref_act1_r, act2, ref_act2_r));
          if (mismatch_s) begin
            state_s = ST_ERROR;
          end else begin
            latch_s = (c1 == ZERO_W);
            if (exp_c1_r == LAST_C1) begin
              step_done_s = 1'b1;
              exp_c1_s    = ZERO_W;
              exp_i_s     = exp_i_r + 2'd1;
            end else begin
              exp_c1_s = exp_c1_r + ONE_W;
            end
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      ST_ERROR: begin
`ifdef EXP1_8_AUTO_RESYNC_EN
        // One clock in ERROR, then hunt again without waiting for chk_en.
        state_s = ST_HUNT;
`else
        state_s = ST_ERROR;
`endif
      end
      default: begin
        state_s = ST_HUNT;
      end
    endcase
  end

  // clr_err releases ERROR, including an error detected in the same cycle.
  assign state_nxt_s = (clr_err && (state_s == ST_ERROR)) ? ST_HUNT : state_s;

  // FSM state and expected-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_HUNT;
      exp_c1_r <= ZERO_W;
      exp_i_r  <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      exp_c1_r <= exp_c1_s;
      exp_i_r  <= exp_i_s;
    end
  end

  // Step reference registers, loaded on each accepted c1 = 0 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_x_r    <= ZERO_W;
      ref_y_r    <= ZERO_W;
      ref_act1_r <= ZERO_W;
      ref_act2_r <= ZERO_W;
    end else if (latch_s) begin
      ref_x_r    <= x;
      ref_y_r    <= y;
      ref_act1_r <= act1;
      ref_act2_r <= act2;
    end else begin
      ref_x_r    <= ref_x_r;
      ref_y_r    <= ref_y_r;
      ref_act1_r <= ref_act1_r;
      ref_act2_r <= ref_act2_r;
    end
  end

  // Lock indication and error reporting; clear wins over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_flag_r  <= 1'b0;
      err_cnt_r   <= ZERO_CNT;
    end else begin
      locked_r    <= (state_nxt_s == ST_LOCKED);
      err_pulse_r <= mismatch_s;
      if (clr_err) begin
        err_flag_r <= 1'b0;
        err_cnt_r  <= ZERO_CNT;
      end else if (mismatch_s) begin
        err_flag_r <= 1'b1;
        err_cnt_r  <= (err_cnt_r == CNT_MAX) ? CNT_MAX : (err_cnt_r + ONE_CNT);
      end else begin
        err_flag_r <= err_flag_r;
        err_cnt_r  <= err_cnt_r;
      end
    end
  end

  // Step statistics and action-code capture at each completed step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r <= ZERO_CNT;
      cap_act1_r <= ZERO_W;
      cap_act2_r <= ZERO_W;
      cap_step_r <= 2'd0;
    end else if (step_done_s) begin
      step_cnt_r <= step_cnt_r + ONE_CNT;
      cap_act1_r <= act1;
      cap_act2_r <= act2;
      cap_step_r <= i;
    end else begin
      step_cnt_r <= step_cnt_r;
      cap_act1_r <= cap_act1_r;
      cap_act2_r <= cap_act2_r;
      cap_step_r <= cap_step_r;
    end
  end

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_flag  = err_flag_r;
  assign err_cnt   = err_cnt_r;
  assign step_cnt  = step_cnt_r;
  assign cap_act1  = cap_act1_r;
  assign cap_act2  = cap_act2_r;
  assign cap_step  = cap_step_r;

endmodule

// File: doc/exp1_8_seq_checker.md
Name: exp1_8_seq_checker

Overview:
- Receiving end of the exp1_8 step-sequence interface (c1, x, y, act1, act2, i); instantiated beside the generator in exp1_8_tb.
- Tracks the expected step index and in-step counter and flags any deviation from the defined sequence.
- Captures the action codes at each step boundary and keeps error and step statistics.

Parameters:
- STEP_LEN, 8, cycles per step; c1 counts 0..STEP_LEN-1 (legal 2..256).
- W, 8, width of c1, x, y, act1 and act2.
- CNT_W, 16, width of err_cnt and step_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chk_en  in  1  sample enable; inputs are ignored when low.
- c1  in  W  producer in-step cycle counter.
- x  in  W  producer data x.
- y  in  W  producer data y.
- act1  in  W  producer action code 1.
- act2  in  W  producer action code 2.
- i  in  2  producer step index.
- clr_err  in  1  synchronous clear of err_cnt, err_flag and the ERROR state.
- locked  out  1  checker is synchronised to the sequence.
- err_pulse  out  1  one-cycle pulse on each detected mismatch.
- err_flag  out  1  sticky error indicator.
- err_cnt  out  CNT_W  saturating mismatch count.
- step_cnt  out  CNT_W  completed steps while locked; wraps.
- cap_act1  out  W  act1 captured on the last cycle of a step.
- cap_act2  out  W  act2 captured on the last cycle of a step.
- cap_step  out  2  value of i for the captured step.

Behaviour:
- Reset (async, rst_n=0): every output is 0. FSM goes to HUNT. Expected registers exp_i and exp_c1 are 0.
- Sequence definition (per chk_en sample):
  - c1 increments by 1 each sample.
  - After c1 = STEP_LEN-1, the next sample has c1 = 0 and i = (i+1) mod 4 (3 wraps to 0).
  - x, y, act1 and act2 hold stable within a step. They may change only on the c1 = 0 sample.
- FSM states (only chk_en=1 cycles advance it; chk_en=0 freezes everything, outputs hold, err_pulse=0):
  - HUNT:
    - Sample with c1==0 and i==0: go to LOCKED; exp_c1=1, exp_i=0; latch x/y/act1/act2 as the step reference.
    - Any other sample: stay in HUNT, no errors.
  - LOCKED:
    - Each sample compares c1 to exp_c1 and i to exp_i. When c1 != 0 it also compares x, y, act1 and act2 to the latched reference.
    - All match:
      - If exp_c1 == STEP_LEN-1: capture act1/act2/i into cap_*; step_cnt += 1; exp_c1 = 0; exp_i += 1 (mod 4).
      - Otherwise: exp_c1 += 1.
      - On a c1==0 sample, relatch the reference.
    - Any mismatch: err_pulse=1 the next cycle; err_flag=1; err_cnt += 1 (saturates at all-ones); locked=0; go to ERROR.
  - ERROR: behaviour is set by the optional feature. clr_err=1 returns to HUNT.
- Output timing:
  - locked is registered: 1 from the cycle after entry to LOCKED.
  - err_pulse is 1 cycle wide, asserted the cycle after the bad sample.
- clr_err:
  - Zeroes err_cnt and err_flag.
  - If clr_err and an error occur in the same cycle, clear wins: count stays 0, but err_pulse still fires.
  - Does not affect step_cnt or the cap_* outputs.
- Reset mid-operation: immediate return to the reset values; the next sync requires a fresh i=0, c1=0 sample.
- Arithmetic:
  - exp_c1 compare is width W; STEP_LEN-1 is truncated to W.
  - exp_i is a 2-bit natural wrap.
  - step_cnt wraps modulo 2^CNT_W.

Optional Feature:
- Macro: EXP1_8_AUTO_RESYNC_EN.
- Defined: ERROR lasts one cycle, then the FSM automatically enters HUNT. err_flag remains sticky until clr_err.
- Undefined: ERROR is absorbing; only clr_err or reset leaves it. Further samples produce no extra err_pulse and no err_cnt increment.

Test Plan:
- Reset then clean sequence, STEP_LEN=8, from i=0,c1=0 -> locked=1 from cycle 2; after 32 samples step_cnt=4, err_cnt=0, cap_step=3.
- Sync from mid-sequence (first sample i=2,c1=5) -> stays HUNT until i=0,c1=0 appears; then locks, no err_pulse.
- Inject c1 jump 3->5 while locked -> one err_pulse, err_cnt=1, err_flag=1, locked=0. With the macro defined, relocks at the next i=0,c1=0; without it, stays unlocked until clr_err.
- Change act1 at c1=4 within step 1 -> error counted. Change act1 at c1=0 of step 2 -> no error, and cap_act1 shows the new value at the end of step 2.
- chk_en low for 10 cycles mid-step, then resume the sequence -> no error; step_cnt continues correctly.
- Assert rst_n=0 mid-step, then release -> all outputs 0, FSM in HUNT; clr_err together with an error in the same cycle -> err_pulse=1, err_cnt=0.
